// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue.
// Holds the in-flight branch record, the fall-through PC increment and the
// default queue geometry (depth and pointer width) used by the top and FIFO.
package branch_resolve_queue_pkg;

  localparam int unsigned BRQ_PC_WIDTH = 32;
  localparam int unsigned PC_INC       = 4;
  localparam int unsigned BRQ_DEPTH    = 4;
  // Pointer index width; the pointers themselves carry one extra wrap bit.
  localparam int unsigned BRQ_PTR_W    = $clog2(BRQ_DEPTH);

  // One predicted conditional branch awaiting resolution.
  typedef struct packed {
    logic [BRQ_PC_WIDTH-1:0] pc;
    logic                    pred;
    logic [BRQ_PC_WIDTH-1:0] target;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// brq_fifo: circular storage of in-flight branch entries.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   wr_en, wr_data - push request and entry (dropped when full)
//   rd_en          - pop the head entry (ignored when empty)
//   clear_to_head  - with a pop: discard every younger entry
//   rd_data        - current head entry
//   full, empty    - occupancy flags derived from the pointers only
module brq_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = BRQ_DEPTH,
  parameter int unsigned PTR_W = BRQ_PTR_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  brq_entry_t wr_data,
  input  logic       rd_en,
  input  logic       clear_to_head,
  output brq_entry_t rd_data,
  output logic       full,
  output logic       empty
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0] wr_ptr_r;
  logic [PTR_W:0] rd_ptr_r;
  logic [PTR_W:0] wr_ptr_nxt_s;
  logic [PTR_W:0] rd_ptr_nxt_s;
  logic           push_s;
  logic           pop_s;
  brq_entry_t     mem_r [DEPTH];

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]) &&
                   (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]);
  assign rd_data = mem_r[rd_ptr_r[PTR_W-1:0]];

  // Pointer next-state: a clearing pop snaps wr_ptr onto the advanced rd_ptr,
  // which both empties the queue and discards a same-cycle push.
  always_comb begin
    pop_s        = rd_en && !empty;
    push_s       = wr_en && !full && !(clear_to_head && pop_s);
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (clear_to_head && pop_s) begin
      wr_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: tracks predicted conditional branches until execute
// resolves them in order, strobes the predictor update and flags mispredicts.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   push_valid/pc/pred/target        - predicted branch from fetch
//   push_ready                       - queue not full
//   resolve_valid/taken/target       - resolution of the oldest branch
//   Br_Dectected, Br_Comp_Result     - registered predictor update strobe
//   flush, redirect_pc               - registered one-cycle mispredict redirect
//   mispredict_cnt                   - saturating mispredict count
//   underflow_err                    - sticky: resolve seen with queue empty
// PC_WIDTH must equal BRQ_PC_WIDTH because the entry record is shared.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned PC_WIDTH = BRQ_PC_WIDTH,
  parameter int unsigned DEPTH    = BRQ_DEPTH,
  parameter int unsigned PTR_W    = BRQ_PTR_W,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid,
  input  logic [PC_WIDTH-1:0] push_pc,
  input  logic                push_pred,
  input  logic [PC_WIDTH-1:0] push_target,
  output logic                push_ready,
  input  logic                resolve_valid,
  input  logic                resolve_taken,
  input  logic [PC_WIDTH-1:0] resolve_target,
  output logic                Br_Dectected,
  output logic                Br_Comp_Result,
  output logic                flush,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0]    mispredict_cnt,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  brq_entry_t          push_entry_s;
  brq_entry_t          head_s;
  logic                full_s;
  logic                empty_s;
  logic                resolve_fire_s;
  logic                mispredict_s;
  logic                br_det_nxt_s;
  logic                br_res_nxt_s;
  logic                flush_nxt_s;
  logic [PC_WIDTH-1:0] redirect_nxt_s;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                uf_nxt_s;
  logic                br_det_r;
  logic                br_res_r;
  logic                flush_r;
  logic [PC_WIDTH-1:0] redirect_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                uf_r;

  // Push readiness depends on pointers only, never on a concurrent pop.
  assign push_ready = !full_s;

  // Pack the fetch-side branch into a queue entry.
  always_comb begin
    push_entry_s        = '0;
    push_entry_s.pc     = push_pc;
    push_entry_s.pred   = push_pred;
    push_entry_s.target = push_target;
  end

  brq_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (push_valid),
    .wr_data       (push_entry_s),
    .rd_en         (resolve_fire_s),
    .clear_to_head (resolve_fire_s && mispredict_s),
    .rd_data       (head_s),
    .full          (full_s),
    .empty         (empty_s)
  );

  // Compare the resolution against the head prediction; the target only
  // matters when the branch was actually taken.
  always_comb begin
    resolve_fire_s = resolve_valid && !empty_s;
    mispredict_s   = (resolve_taken != head_s.pred) ||
                     (resolve_taken && (resolve_target != head_s.target));
  end

  // Next values for the update strobe, flush/redirect, counter and error.
  always_comb begin
    br_det_nxt_s   = 1'b0;
    br_res_nxt_s   = 1'b0;
    flush_nxt_s    = 1'b0;
    redirect_nxt_s = redirect_r;
    cnt_nxt_s      = cnt_r;
    uf_nxt_s       = uf_r;
    if (resolve_fire_s) begin
      br_det_nxt_s = 1'b1;
      br_res_nxt_s = resolve_taken;
    end else begin
      br_det_nxt_s = 1'b0;
      br_res_nxt_s = 1'b0;
    end
    if (resolve_fire_s && mispredict_s) begin
      flush_nxt_s    = 1'b1;
      redirect_nxt_s = resolve_taken ? resolve_target
                                     : head_s.pc + PC_WIDTH'(PC_INC);
      if (cnt_r != CNT_MAX) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      flush_nxt_s    = 1'b0;
      redirect_nxt_s = redirect_r;
      cnt_nxt_s      = cnt_r;
    end
    if (resolve_valid && empty_s) begin
      uf_nxt_s = 1'b1;
    end else begin
      uf_nxt_s = uf_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_det_r   <= 1'b0;
      br_res_r   <= 1'b0;
      flush_r    <= 1'b0;
      redirect_r <= {PC_WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      uf_r       <= 1'b0;
    end else begin
      br_det_r   <= br_det_nxt_s;
      br_res_r   <= br_res_nxt_s;
      flush_r    <= flush_nxt_s;
      redirect_r <= redirect_nxt_s;
      cnt_r      <= cnt_nxt_s;
      uf_r       <= uf_nxt_s;
    end
  end

  assign Br_Dectected   = br_det_r;
  assign Br_Comp_Result = br_res_r;
  assign flush          = flush_r;
  assign redirect_pc    = redirect_r;
  assign mispredict_cnt = cnt_r;
  assign underflow_err  = uf_r;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue. The counter is instantiated
// 4 bits wide so saturation is reachable in a few dozen cycles.
module tb_branch_resolve_queue;

  localparam int CNT_W = 4;

  typedef struct {
    logic        taken;
    logic        flush;
    logic [31:0] redirect;
    logic [31:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid;
  logic [31:0]      push_pc;
  logic             push_pred;
  logic [31:0]      push_target;
  logic             push_ready;
  logic             resolve_valid;
  logic             resolve_taken;
  logic [31:0]      resolve_target;
  logic             Br_Dectected;
  logic             Br_Comp_Result;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] mispredict_cnt;
  logic             underflow_err;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] exp_cnt = 32'd0;

  branch_resolve_queue #(
    .PC_WIDTH (32),
    .DEPTH    (4),
    .PTR_W    (2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .push_valid     (push_valid),
    .push_pc        (push_pc),
    .push_pred      (push_pred),
    .push_target    (push_target),
    .push_ready     (push_ready),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .Br_Dectected   (Br_Dectected),
    .Br_Comp_Result (Br_Comp_Result),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .mispredict_cnt (mispredict_cnt),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    push_valid    = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    push_valid  = 1'b1;
    push_pc     = pc;
    push_pred   = pred;
    push_target = tgt;
  endtask

  // Drive a resolve that should hit a non-empty queue and queue its response.
  task automatic set_resolve(input logic taken, input logic [31:0] tgt,
                             input logic exp_flush, input logic [31:0] exp_redirect);
    exp_t e;
    resolve_valid  = 1'b1;
    resolve_taken  = taken;
    resolve_target = tgt;
    if (exp_flush && exp_cnt != 32'd15) exp_cnt = exp_cnt + 32'd1;
    e.taken    = taken;
    e.flush    = exp_flush;
    e.redirect = exp_redirect;
    e.cnt      = exp_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe consumes one expected response; flush never alone.
  always @(negedge clk) begin
    if (!rst) begin
      if (Br_Dectected) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: Br_Dectected=1 with no resolve outstanding");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("comp_result", {31'd0, Br_Comp_Result}, {31'd0, e.taken});
          check("flush", {31'd0, flush}, {31'd0, e.flush});
          if (e.flush) check("redirect_pc", redirect_pc, e.redirect);
          check("mispredict_cnt", {28'd0, mispredict_cnt}, e.cnt);
        end
      end else begin
        check("flush_without_strobe", {31'd0, flush}, 32'd0);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    push_valid     = 1'b0;
    push_pc        = 32'd0;
    push_pred      = 1'b0;
    push_target    = 32'd0;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    resolve_target = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_push_ready", {31'd0, push_ready}, 32'd1);
    check("rst_br_det", {31'd0, Br_Dectected}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_cnt", {28'd0, mispredict_cnt}, 32'd0);
    check("rst_underflow", {31'd0, underflow_err}, 32'd0);
    rst = 1'b0;
    step();

    // Correct taken prediction.
    set_push(32'h100, 1'b1, 32'h200); step();
    set_resolve(1'b1, 32'h200, 1'b0, 32'h0); step();
    // Direction mispredict: fall through to pc+4.
    set_push(32'h100, 1'b1, 32'h200); step();
    set_resolve(1'b0, 32'h300, 1'b1, 32'h104); step();
    // Target mispredict.
    set_push(32'h40, 1'b1, 32'h80); step();
    set_resolve(1'b1, 32'h90, 1'b1, 32'h90); step();
    // Correct not-taken (target ignored), then predicted-not-taken but taken.
    set_push(32'h300, 1'b0, 32'h999); step();
    set_resolve(1'b0, 32'h123, 1'b0, 32'h0); step();
    set_push(32'h500, 1'b0, 32'h0); step();
    set_resolve(1'b1, 32'h600, 1'b1, 32'h600); step();

    // Fill, drop a 5th push, then drain in order back-to-back.
    set_push(32'h10, 1'b1, 32'h20); step();
    set_push(32'h30, 1'b0, 32'h40); step();
    set_push(32'h50, 1'b1, 32'h60); step();
    check("ready_at_3", {31'd0, push_ready}, 32'd1);
    set_push(32'h70, 1'b0, 32'h80); step();
    check("ready_full", {31'd0, push_ready}, 32'd0);
    set_push(32'h90, 1'b0, 32'hA0); step();
    set_resolve(1'b1, 32'h20, 1'b0, 32'h0);
    check("ready_full_with_resolve", {31'd0, push_ready}, 32'd0);
    step();
    set_resolve(1'b0, 32'h0, 1'b0, 32'h0); step();
    set_resolve(1'b1, 32'h60, 1'b0, 32'h0); step();
    set_resolve(1'b0, 32'h0, 1'b0, 32'h0); step();
    check("ready_after_drain", {31'd0, push_ready}, 32'd1);

    // Concurrent push and correct resolve keep occupancy.
    set_push(32'h700, 1'b1, 32'h710); step();
    set_push(32'h720, 1'b0, 32'h0);
    set_resolve(1'b1, 32'h710, 1'b0, 32'h0); step();
    set_resolve(1'b0, 32'h0, 1'b0, 32'h0); step();
    step();

    // Mispredict clears younger entries and discards the same-cycle push.
    set_push(32'h1000, 1'b1, 32'h1100); step();
    set_push(32'h2000, 1'b1, 32'h2100); step();
    set_push(32'h3000, 1'b1, 32'h3100); step();
    set_push(32'h4000, 1'b1, 32'h4100);
    set_resolve(1'b0, 32'h0, 1'b1, 32'h1004); step();
    step();
    check("no_underflow_yet", {31'd0, underflow_err}, 32'd0);
    resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h2100;
    step();
    step();
    check("underflow_set", {31'd0, underflow_err}, 32'd1);
    step();
    check("underflow_sticky", {31'd0, underflow_err}, 32'd1);

    // Reset mid-operation with two entries and a mispredicting resolve pending.
    set_push(32'h5000, 1'b1, 32'h5100); step();
    set_push(32'h6000, 1'b1, 32'h6100); step();
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_br_det", {31'd0, Br_Dectected}, 32'd0);
    check("mid_rst_flush", {31'd0, flush}, 32'd0);
    check("mid_rst_redirect", redirect_pc, 32'd0);
    check("mid_rst_cnt", {28'd0, mispredict_cnt}, 32'd0);
    check("mid_rst_underflow", {31'd0, underflow_err}, 32'd0);
    check("mid_rst_ready", {31'd0, push_ready}, 32'd1);
    resolve_valid = 1'b0;
    exp_cnt = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    step();
    step();
    check("entries_lost", {31'd0, underflow_err}, 32'd1);

    // Counter saturation: 17 mispredicts on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      set_push(32'h8000 + 32'(i) * 32'h10, 1'b1, 32'h9000);
      step();
      set_resolve(1'b0, 32'h0, 1'b1, 32'h8004 + 32'(i) * 32'h10);
      step();
    end
    step();
    check("cnt_saturated", {28'd0, mispredict_cnt}, 32'd15);

    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
